// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous RAM.
// Each access runs IDLE -> ISSUE -> (WAIT for reads) -> ACK.
module mem_port_arbiter #(
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  c,
  input  logic                  r,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  owner_b
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_grant;
  logic                  w_grant_b;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_we;
  logic                  r_owner_b;
  logic                  r_last_b;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_a_rdata;
  logic [WIDTH-1:0]      r_b_rdata;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic                  r_mem_we;
  logic                  r_busy;

  // State register
  always_ff @(posedge c) begin
    if (!r) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and round-robin grant decision
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (a_req && b_req) begin
          // On a tie the port that was not served last wins.
          w_grant   = 1'b1;
          w_grant_b = ~r_last_b;
        end else if (a_req) begin
          w_grant   = 1'b1;
          w_grant_b = 1'b0;
        end else if (b_req) begin
          w_grant   = 1'b1;
          w_grant_b = 1'b1;
        end else begin
          w_grant   = 1'b0;
          w_grant_b = 1'b0;
        end
        if (w_grant) begin
          w_next = ST_ISSUE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_next = ST_ACK;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(0)) begin
          w_next = ST_ACK;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, latency counter, read capture and registered outputs
  always_ff @(posedge c) begin
    if (!r) begin
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_wdata   <= {WIDTH{1'b0}};
      r_we      <= 1'b0;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_cnt     <= CNT_W'(0);
      r_a_rdata <= {WIDTH{1'b0}};
      r_b_rdata <= {WIDTH{1'b0}};
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_a_ack  <= (w_next == ST_ACK) && !r_owner_b;
      r_b_ack  <= (w_next == ST_ACK) && r_owner_b;
      r_busy   <= (w_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_addr    <= w_grant_b ? b_addr  : a_addr;
            r_wdata   <= w_grant_b ? b_wdata : a_wdata;
            r_we      <= w_grant_b ? b_we    : a_we;
            r_mem_we  <= w_grant_b ? b_we    : a_we;
            r_owner_b <= w_grant_b;
          end
        end
        ST_ISSUE: begin
          if (!r_we) begin
            r_cnt <= CNT_W'(READ_LATENCY - 1);
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(0)) begin
            if (r_owner_b) begin
              r_b_rdata <= mem_rdata;
            end else begin
              r_a_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_ACK:  r_last_b <= r_owner_b;
        default: r_last_b <= r_last_b;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_mem_we;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign busy      = r_busy;
  assign owner_b   = r_owner_b;

endmodule
